// File: rtl/div_pkg.sv
// Shared definitions for the multi-channel clock divider: output mode encoding,
// smallest legal divisor and the channel-index width helper.
package div_pkg;

    localparam int MIN_DIV = 2;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    // A single-channel build still carries a one-bit channel index.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: period counter, active/shadow divisor and mode, pending flag
// and registered div_clk/div_tick outputs.
module div_channel
    import div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  div_mode_e        wr_mode,
    output logic             pending,
    output logic             div_clk,
    output logic             div_tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    div_mode_e        mode_q;
    logic [CNT_W-1:0] shd_div;
    div_mode_e        shd_mode;
    logic             run;

    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    div_mode_e        mode_nxt;
    logic             run_nxt;
    logic             apply;
    logic [CNT_W-1:0] half;
    logic             clk_nxt;
    logic             tick_nxt;

    // The outputs are registered from the next-state values, so div_clk/div_tick
    // line up with the cnt value held in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path through this block
        // leaves one unassigned, which would otherwise infer a latch.
        cnt_nxt  = cnt;
        div_nxt  = div_q;
        mode_nxt = mode_q;
        run_nxt  = run;
        apply    = 1'b0;

        if (!en) begin
            run_nxt = 1'b0;
            cnt_nxt = '0;
            apply   = pending;
        end else if (!run) begin
            run_nxt = 1'b1;
            cnt_nxt = '0;
            apply   = pending;
        end else if (cnt == div_q - CNT_W'(1)) begin
            cnt_nxt = '0;
            apply   = pending;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        // New settings only take effect at a period boundary (or while stopped).
        if (apply) begin
            div_nxt  = shd_div;
            mode_nxt = shd_mode;
        end

        half = div_nxt >> 1;
        if (mode_nxt == MODE_SQUARE) begin
            clk_nxt  = run_nxt && (cnt_nxt >= half);
            tick_nxt = run_nxt && (cnt_nxt == half);
        end else begin
            clk_nxt  = run_nxt && (cnt_nxt == div_nxt - CNT_W'(1));
            tick_nxt = clk_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt      <= '0;
            div_q    <= CNT_W'(DEFAULT_DIV);
            mode_q   <= MODE_SQUARE;
            shd_div  <= CNT_W'(DEFAULT_DIV);
            shd_mode <= MODE_SQUARE;
            pending  <= 1'b0;
            run      <= 1'b0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples the
            // pre-edge values no matter the statement order.
            cnt      <= cnt_nxt;
            div_q    <= div_nxt;
            mode_q   <= mode_nxt;
            run      <= run_nxt;
            div_clk  <= clk_nxt;
            div_tick <= tick_nxt;
            if (wr) begin
                shd_div  <= wr_div;
                shd_mode <= wr_mode;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_channel_divider.sv
// Multi-channel programmable clock divider: configuration decode, write validation
// and error flag; each channel is an independent div_channel instance.
module multi_channel_divider
    import div_pkg::*;
#(
    parameter int   CHANNELS    = 2,
    parameter int   CNT_W       = 16,
    parameter int   DEFAULT_DIV = 10000,
    localparam int  CH_W        = ch_idx_w(CHANNELS)
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] div_tick
);

    logic [CHANNELS-1:0]  pending;
    logic [2**CH_W-1:0]   pend_pad;
    logic                 ch_ok;
    logic                 div_ok;
    logic                 accept;
    logic                 wr_ok;

    // Out-of-range channel indices read as "not pending" so the write is taken
    // and then rejected with cfg_err instead of stalling the requester.
    always_comb begin
        pend_pad                 = '0;
        pend_pad[CHANNELS-1:0]   = pending;
    end

    assign cfg_ready = ~pend_pad[cfg_ch];
    assign ch_ok     = int'(cfg_ch) < CHANNELS;
    assign div_ok    = cfg_div >= CNT_W'(MIN_DIV);
    assign accept    = cfg_valid && cfg_ready;
    assign wr_ok     = accept && ch_ok && div_ok;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !(ch_ok && div_ok);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .en        (ch_en[i]),
            .wr        (wr_ok && (int'(cfg_ch) == i)),
            .wr_div    (cfg_div),
            .wr_mode   (div_mode_e'(cfg_mode)),
            .pending   (pending[i]),
            .div_clk   (div_clk[i]),
            .div_tick  (div_tick[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_divider.sv
// Scoreboard bench for multi_channel_divider: stimulus pushes expected output
// events (edges, ticks, errors with their cycle numbers); a monitor pops them.
module tb_multi_channel_divider;

    // Three channels so that channel index 3 is encodable yet out of range.
    localparam int NCH = 3;
    localparam int CW  = 2;

    typedef enum int {EV_RISE, EV_FALL, EV_TICK, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       ch;
        int       cyc;
    } ev_t;

    logic            sys_clk;
    logic            sys_rst_n;
    logic [NCH-1:0]  ch_en;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_ch;
    logic [15:0]     cfg_div;
    logic            cfg_mode;
    logic            cfg_err;
    logic [NCH-1:0]  div_clk;
    logic [NCH-1:0]  div_tick;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  horizon = 0;
    ev_t exp_q[$];
    logic [NCH-1:0] prev_clk = '0;

    multi_channel_divider #(
        .CHANNELS    (NCH),
        .CNT_W       (16),
        .DEFAULT_DIV (10000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .div_tick  (div_tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_ev(input ev_kind_e k, input int ch, input int c);
        ev_t e;
        if (c <= horizon) begin
            e.kind = k;
            e.ch   = ch;
            e.cyc  = c;
            exp_q.push_back(e);
        end
    endfunction

    // Square wave: low for d/2 cycles from base, rise+tick, fall at the next period.
    function automatic void push_square(input int ch, input int base, input int d, input int n);
        for (int p = 0; p < n; p++) begin
            push_ev(EV_RISE, ch, base + p * d + d / 2);
            push_ev(EV_TICK, ch, base + p * d + d / 2);
            push_ev(EV_FALL, ch, base + (p + 1) * d);
        end
    endfunction

    function automatic void push_pulse(input int ch, input int base, input int d, input int n);
        for (int p = 0; p < n; p++) begin
            push_ev(EV_RISE, ch, base + p * d + d - 1);
            push_ev(EV_TICK, ch, base + p * d + d - 1);
            push_ev(EV_FALL, ch, base + (p + 1) * d);
        end
    endfunction

    task automatic match(input ev_kind_e k, input int ch);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].kind == k && exp_q[i].ch == ch) idx = i;
        end
        if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL unexpected %s ch%0d: seen at cycle %0d, none expected", k.name(), ch, cyc);
        end else begin
            check($sformatf("%s ch%0d cycle", k.name(), ch), cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_clk = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (div_clk[c] && !prev_clk[c]) match(EV_RISE, c);
                if (!div_clk[c] && prev_clk[c]) match(EV_FALL, c);
                if (div_tick[c]) match(EV_TICK, c);
            end
            if (cfg_err) match(EV_ERR, 0);
            prev_clk = div_clk;
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k0, b_cyc, c_cyc, w_cyc, e_cyc, x_cyc, s_cyc, e3, k3, n;

        sys_rst_n = 1'b0;
        ch_en     = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_mode  = 1'b0;

        repeat (3) @(negedge sys_clk);
        #1;
        check("reset div_clk", div_clk, 0);
        check("reset div_tick", div_tick, 0);
        check("reset cfg_err", cfg_err, 0);
        check("reset cfg_ready", cfg_ready, 1);

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Whole schedule of the run phase, fixed relative to the enable cycle.
        k0    = cyc;
        b_cyc = k0 + 1 + 10000;
        c_cyc = b_cyc + 5;
        w_cyc = c_cyc + 10;
        e_cyc = w_cyc + 3;
        x_cyc = e_cyc + 20;
        s_cyc = x_cyc + 40;
        while (((s_cyc - c_cyc) % 6) != 4) s_cyc++;
        horizon = s_cyc;
        push_square(0, k0 + 1, 10000, 1);
        push_square(0, b_cyc, 5, 1);
        push_square(0, c_cyc, 6, 30);
        push_pulse(1, e_cyc + 1, 4, 40);
        push_ev(EV_ERR, 0, x_cyc + 1);
        push_ev(EV_ERR, 0, x_cyc + 4);

        ch_en = 3'b001;

        wait_to(k0 + 100);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd5;
        cfg_mode  = 1'b0;
        #1 check("ready before write", cfg_ready, 1);
        @(negedge sys_clk);
        cfg_div = 16'd6;
        #1 check("ready while pending", cfg_ready, 0);
        n = 0;
        while (!cfg_ready && n < 20000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check("second write accepted at wrap", cyc, b_cyc);
        @(negedge sys_clk);
        cfg_valid = 1'b0;

        // Pulse mode on a stopped channel: applied immediately, then enabled.
        wait_to(w_cyc);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd4;
        cfg_mode  = 1'b1;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
        wait_to(e_cyc);
        ch_en = 3'b011;

        wait_to(x_cyc);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd1;
        cfg_mode  = 1'b0;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
        wait_to(x_cyc + 3);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_div   = 16'd7;
        #1 check("ready for bad channel", cfg_ready, 1);
        @(negedge sys_clk);
        cfg_valid = 1'b0;

        wait_to(s_cyc);
        #1;
        check("run phase events left over", exp_q.size(), 0);
        exp_q.delete();
        check("ch0 high before reset", div_clk[0], 1);
        sys_rst_n = 1'b0;
        ch_en     = '0;
        #1;
        check("async drop div_clk", div_clk, 0);
        check("async drop div_tick", div_tick, 0);

        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Divide-by-8 on ch0, reset again when its counter reads 3.
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd8;
        cfg_mode  = 1'b0;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
        @(negedge sys_clk);
        e3 = cyc;
        ch_en = 3'b001;
        wait_to(e3 + 4);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("reset at cnt3 div_clk", div_clk, 0);
        check("reset at cnt3 div_tick", div_tick, 0);
        check("reset at cnt3 cfg_ready", cfg_ready, 1);

        @(negedge sys_clk);
        k3 = cyc;
        horizon = k3 + 1 + 10002;
        push_square(0, k3 + 1, 10000, 1);
        sys_rst_n = 1'b1;
        wait_to(horizon);
        #1;
        check("restart events left over", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
